// File: rtl/mdu_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit: op encodings,
// controller states and divider sizing.
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    // Two's-complement magnitude when the operand is treated as signed.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// One restoring radix-2 division step: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, emit one quotient bit.
module mdu_div_iter
    import mdu_pkg::*;
(
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shifted;
    logic [32:0] diff;

    // rem_i < dvs_i always holds, so the 33-bit difference sign is exact.
    always_comb begin
        shifted = {rem_i, quo_i[31]};
        diff    = shifted - {1'b0, dvs_i};
        if (!diff[32]) begin
            rem_o = diff[31:0];
            quo_o = {quo_i[30:0], 1'b1};
        end else begin
            rem_o = shifted[31:0];
            quo_o = {quo_i[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/exe_mdu.sv
// Multiply/divide unit with HI/LO registers: single-cycle registered multiply,
// 32-step restoring divide on magnitudes followed by a sign-fix cycle.
module exe_mdu
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        rd_hi,
    output logic        busy,
    output logic        done,
    output logic [31:0] mdu_out
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rem_q, rem_d;
    logic [31:0]        quo_q, quo_d;
    logic [31:0]        dvs_q, dvs_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               sgn_q, sgn_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [31:0]        step_rem;
    logic [31:0]        step_quo;
    logic [63:0]        mul_a_ext;
    logic [63:0]        mul_b_ext;
    logic [63:0]        product;
    logic               div_signed;

    mdu_div_iter u_div_iter (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // Multiply operands share the quotient/divisor registers; the low 64 bits
    // of the extended product equal the signed or unsigned 64-bit result.
    assign mul_a_ext = {{32{sgn_q & quo_q[31]}}, quo_q};
    assign mul_b_ext = {{32{sgn_q & dvs_q[31]}}, dvs_q};
    assign product   = mul_a_ext * mul_b_ext;

    assign div_signed = (op == OP_DIV);
    assign mdu_out    = rd_hi ? hi_q : lo_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            quo_d   = a;
                            dvs_d   = b;
                            sgn_d   = (op == OP_MULT);
                            state_d = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (b == 32'd0) begin
                                // Preload the fixed divide-by-zero result; FIX passes it through.
                                rem_d   = a;
                                quo_d   = 32'hFFFF_FFFF;
                                neg_q_d = 1'b0;
                                neg_r_d = 1'b0;
                                cnt_d   = '0;
                                state_d = ST_FIX;
                            end else begin
                                rem_d   = 32'd0;
                                quo_d   = mag32(a, div_signed);
                                dvs_d   = mag32(b, div_signed);
                                neg_q_d = div_signed & (a[31] ^ b[31]);
                                neg_r_d = div_signed & a[31];
                                cnt_d   = CNT_W'(DIV_STEPS - 1);
                                state_d = ST_DIV;
                            end
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                busy    = 1'b1;
                state_d = ST_IDLE;
                if (!flush) begin
                    {hi_d, lo_d} = product;
                    done         = 1'b1;
                end
            end
            ST_DIV: begin
                busy = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (cnt_q == '0) begin
                        state_d = ST_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_FIX: begin
                busy    = 1'b1;
                state_d = ST_IDLE;
                if (!flush) begin
                    lo_d = neg_q_q ? (32'd0 - quo_q) : quo_q;
                    hi_d = neg_r_q ? (32'd0 - rem_q) : rem_q;
                    done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: doc/exe_mdu.md
EXE_MDU -- requirements
Module: exe_mdu

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, asynchronous, active-low; one clock domain only.
REQ-003 start  in  1  request from EXE stage; sampled only when busy=0.
REQ-004 op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 NOP.
REQ-005 a  in  32  rs_value (dividend / multiplicand / MTHI-MTLO source).
REQ-006 b  in  32  rt_value (divisor / multiplier).
REQ-007 flush  in  1  abort in-flight operation (branch/exception kill).
REQ-008 rd_hi  in  1  read select: 1 HI, 0 LO (MFHI/MFLO).
REQ-009 busy  out  1  operation in flight; ID stage stalls any MDU instruction while 1.
REQ-010 done  out  1  one-cycle pulse in the cycle HI/LO take a MULT/DIV result.
REQ-011 mdu_out  out  32  rd_hi ? HI : LO, combinational from registers; feeds WB data select 11.

Function
REQ-012 States IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-013 IDLE + start + op MULT/MULTU -> MUL; operands latched; next edge: {HI,LO} = 64-bit product (signed or unsigned), done=1, -> IDLE; busy=1 during MUL only.
REQ-014 IDLE + start + op DIV/DIVU -> DIV; magnitudes latched (signed ops: two's-complement absolute values, signs stored); counter loaded 31.
REQ-015 DIV: one restoring radix-2 step per cycle (shift remainder, trial subtract, quotient bit); counter decrements; counter=0 step -> FIX.
REQ-016 FIX: apply signs (quotient negative iff sign(a)^sign(b), remainder takes sign(a)); LO=quotient, HI=remainder, done=1, -> IDLE.
REQ-017 Divide latency: start edge + 32 DIV cycles + 1 FIX = done on 34th edge after start accepted; busy=1 for 33 cycles.
REQ-018 Divide by zero: no iteration; next state FIX directly; LO=32'hFFFF_FFFF, HI=a; done pulses on 2nd edge.
REQ-019 DIV 32'h8000_0000 / 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0 (falls out of the magnitude datapath; no special case, no trap).
REQ-020 MTHI/MTLO in IDLE: HI or LO = a on next edge; busy stays 0; done stays 0.
REQ-021 start while busy=1: ignored, no effect on state or operands.
REQ-022 flush in MUL/DIV/FIX: -> IDLE next edge; HI/LO unchanged; done=0; flush in IDLE with start: start discarded.
REQ-023 mdu_out reflects new HI/LO in the cycle after done (no internal bypass); forwarding is the pipeline's responsibility.
REQ-024 op 6-7 with start: no state change.

Reset
REQ-025 rst_n=0 asynchronously: state IDLE, HI=0, LO=0, counter=0, busy=0, done=0, mdu_out=0.
REQ-026 Reset mid-divide: partial results discarded; first edge after rst_n rises accepts a new start.

Structure
REQ-027 Package mdu_pkg: op encoding constants, state enumeration, DIV_STEPS=32.
REQ-028 Sub-module mdu_div_iter: one restoring-division step (remainder/quotient in, remainder/quotient out), combinational; iteration control and sign fix stay in exe_mdu.
REQ-029 Multiplier: single 32x32 signed/unsigned combinational product registered once; no multi-cycle path constraints.

Verification
REQ-030 MULT a=32'hFFFF_FFFE (-2), b=3 -> after 1 edge done=1, HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA; MULTU same operands -> HI=2, LO=32'hFFFF_FFFA.
REQ-031 DIV a=-7, b=2 -> busy 33 cycles, done on 34th edge, LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1); DIVU 7/2 -> LO=3, HI=1.
REQ-032 DIVU a=5, b=0 -> done on 2nd edge, LO=32'hFFFF_FFFF, HI=5; DIV 32'h8000_0000/-1 -> LO=32'h8000_0000, HI=0.
REQ-033 Start DIV, assert start(MULT) at cycle 5, flush at cycle 10 -> MULT ignored, IDLE at cycle 11, HI/LO keep prior values, no done pulse.
REQ-034 MTHI a=32'h1234_5678, then MTLO a=32'h9ABC_DEF0 -> busy never 1; rd_hi=1 gives 32'h1234_5678, rd_hi=0 gives 32'h9ABC_DEF0.
REQ-035 rst_n low at DIV cycle 20 (asynchronous, mid-cycle) -> busy, done, HI, LO, mdu_out all 0 immediately; fresh DIVU 9/3 afterwards -> LO=3, HI=0.
